// File: rtl/minv_mdiv_seq_pkg.sv
// minv_mdiv_seq_pkg
// Shared definitions for the MINV_MDIV word-serial sequencer:
//   - operand/word geometry (WORDS x WORD_W = OP_W)
//   - mode encodings driven onto core_minv_mdiv
//   - sequencer state enum
package minv_mdiv_seq_pkg;

  localparam int WORDS  = 8;
  localparam int WORD_W = 32;
  localparam int OP_W   = 256;
  localparam int IDX_W  = 3;

  localparam logic MODE_INV = 1'b1;  // a^-1 mod p
  localparam logic MODE_DIV = 1'b0;  // b/a mod p

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_P,
    ST_LOAD_B,
    ST_GO,
    ST_WAIT,
    ST_GAP,
    ST_READ,
    ST_FIN
  } state_t;

endpackage

// File: rtl/minv_mdiv_seq_if.sv
// minv_mdiv_seq_if
// 32-bit load / start / read-out bus between the sequencer and the
// MINV_MDIV core.
//   master : sequencer side (drives datain, load strobes, mode, en, outx)
//   slave  : core side (drives regx1out/regx2out, rdy, flag)
interface minv_mdiv_seq_if;
  import minv_mdiv_seq_pkg::*;

  logic [WORD_W-1:0] core_datain;
  logic              core_loada;
  logic              core_loadp;
  logic              core_loadb;
  logic              core_minv_mdiv;
  logic              core_en;
  logic              core_outx1;
  logic              core_outx2;
  logic [WORD_W-1:0] core_regx1out;
  logic [WORD_W-1:0] core_regx2out;
  logic              core_rdy;
  logic              core_flag;

  modport master (
    output core_datain, core_loada, core_loadp, core_loadb,
           core_minv_mdiv, core_en, core_outx1, core_outx2,
    input  core_regx1out, core_regx2out, core_rdy, core_flag
  );

  modport slave (
    input  core_datain, core_loada, core_loadp, core_loadb,
           core_minv_mdiv, core_en, core_outx1, core_outx2,
    output core_regx1out, core_regx2out, core_rdy, core_flag
  );

endinterface

// File: rtl/minv_mdiv_word_ser.sv
// minv_mdiv_word_ser
// Shared 8x32 word path: one 3-bit word counter indexes both the
// serialiser mux (operand -> 32-bit words, LSW first) and the
// deserialiser write slot (32-bit result words -> 256-bit x1/x2).
// Ports:
//   clk, rst            clock, async active-high reset
//   cnt_clr, cnt_step   clear / advance the word counter
//   ser_src, ser_word   operand to serialise, word selected by the counter
//   last_word           counter is on word 7
//   cap_en              write cap_x1/cap_x2 into the slot of the counter
//   par_x1, par_x2      assembled results
module minv_mdiv_word_ser
  import minv_mdiv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_clr,
  input  logic              cnt_step,
  input  logic [OP_W-1:0]   ser_src,
  output logic [WORD_W-1:0] ser_word,
  output logic              last_word,
  input  logic              cap_en,
  input  logic [WORD_W-1:0] cap_x1,
  input  logic [WORD_W-1:0] cap_x2,
  output logic [OP_W-1:0]   par_x1,
  output logic [OP_W-1:0]   par_x2
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OP_W-1:0]  x1_q, x1_d;
  logic [OP_W-1:0]  x2_q, x2_d;

  // The counter wraps 7 -> 0 naturally, so each 8-word phase leaves it
  // at 0 ready for the next phase without an explicit clear.
  always_comb begin
    idx_d = idx_q;
    x1_d  = x1_q;
    x2_d  = x2_q;
    if (cnt_clr) begin
      idx_d = '0;
    end else if (cnt_step) begin
      idx_d = idx_q + 1'b1;
    end
    if (cap_en) begin
      x1_d[idx_q*WORD_W +: WORD_W] = cap_x1;
      x2_d[idx_q*WORD_W +: WORD_W] = cap_x2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
    end else begin
      idx_q <= idx_d;
      x1_q  <= x1_d;
      x2_q  <= x2_d;
    end
  end

  assign ser_word  = ser_src[idx_q*WORD_W +: WORD_W];
  assign last_word = (idx_q == IDX_W'(WORDS - 1));
  assign par_x1    = x1_q;
  assign par_x2    = x2_q;

endmodule

// File: rtl/minv_mdiv_seq.sv
// minv_mdiv_seq
// Word-serial sequencer in front of the MINV_MDIV core. Latches three
// 256-bit operands and a mode on start, loads them into the core 32 bits
// at a time, starts the core, waits for rdy (bounded by TIMEOUT), reads
// x1/x2 back and reports them with a one-cycle done pulse.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, mode              request (IDLE only), 1 = inversion, 0 = division
//   op_a, op_b, op_p         operands (op_b unused for inversion)
//   busy, done, err          handshake / timeout status
//   res_x1, res_x2, res_flag results and core flag
//   core                     core-side bus (master modport)
module minv_mdiv_seq
  import minv_mdiv_seq_pkg::*;
#(
  parameter int RDY_GAP = 2,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  input  logic [OP_W-1:0]   op_p,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OP_W-1:0]   res_x1,
  output logic [OP_W-1:0]   res_x2,
  output logic              res_flag,
  minv_mdiv_seq_if.master   core
);

  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST  = 32'(RDY_GAP - 1);
  localparam logic [31:0] READ_LAST = 32'(WORDS + RD_LAT - 1);
  localparam logic [31:0] STRB_END  = 32'(WORDS);
  localparam logic [31:0] CAP_START = 32'(RD_LAT);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d, p_q, p_d;
  logic             mode_q, mode_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             flag_q, flag_d;

  logic             cnt_clr, cnt_step, cap_en, last_word, load_active;
  logic [OP_W-1:0]  ser_src;
  logic [WORD_W-1:0] ser_word;

  minv_mdiv_word_ser u_word_ser (
    .clk       (clk),
    .rst       (rst),
    .cnt_clr   (cnt_clr),
    .cnt_step  (cnt_step),
    .ser_src   (ser_src),
    .ser_word  (ser_word),
    .last_word (last_word),
    .cap_en    (cap_en),
    .cap_x1    (core.core_regx1out),
    .cap_x2    (core.core_regx2out),
    .par_x1    (res_x1),
    .par_x2    (res_x2)
  );

  // Operand mux and datain gating kept outside the FSM process so the
  // serialiser path does not look like a loop through one always block.
  assign ser_src = (state_q == ST_LOAD_P) ? p_q :
                   (state_q == ST_LOAD_B) ? b_q : a_q;
  assign load_active = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_P) ||
                       (state_q == ST_LOAD_B);
  assign core.core_datain = load_active ? ser_word : '0;

  // Next state and core strobes. cnt_q is a shared cycle counter for
  // WAIT (timeout), GAP and READ; each of those states leaves it at 0.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    flag_d  = flag_q;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    cap_en   = 1'b0;
    core.core_loada = 1'b0;
    core.core_loadp = 1'b0;
    core.core_loadb = 1'b0;
    core.core_en    = 1'b0;
    core.core_outx1 = 1'b0;
    core.core_outx2 = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          p_d     = op_p;
          mode_d  = mode;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        core.core_loada = 1'b1;
        cnt_step = 1'b1;
        if (last_word) state_d = ST_LOAD_P;
      end
      ST_LOAD_P: begin
        core.core_loadp = 1'b1;
        cnt_step = 1'b1;
        if (last_word) state_d = (mode_q == MODE_INV) ? ST_GO : ST_LOAD_B;
      end
      ST_LOAD_B: begin
        core.core_loadb = 1'b1;
        cnt_step = 1'b1;
        if (last_word) state_d = ST_GO;
      end
      ST_GO: begin
        core.core_en = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // rdy wins over a timeout landing on the same cycle
        if (core.core_rdy) begin
          flag_d  = core.core_flag;
          cnt_d   = '0;
          state_d = (RDY_GAP == 0) ? ST_READ : ST_GAP;
        end else if (cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        cnt_clr = 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_READ: begin
        // Strobes on cycles 0..7; the word for strobe k arrives RD_LAT
        // cycles later, so capture runs on cycles RD_LAT..7+RD_LAT.
        core.core_outx1 = (cnt_q < STRB_END);
        core.core_outx2 = (cnt_q < STRB_END);
        cap_en   = (cnt_q >= CAP_START);
        cnt_step = (cnt_q >= CAP_START);
        if (cnt_q == READ_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
    end
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done     = (state_q == ST_FIN);
  assign err      = err_q;
  assign res_flag = flag_q;
  assign core.core_minv_mdiv = (state_q != ST_IDLE) ? mode_q : 1'b0;

endmodule

// File: tb/tb_minv_mdiv_seq.sv
// tb_minv_mdiv_seq
// Drives the sequencer against a small behavioural MINV_MDIV core model.
// Expected results come from a vector table and are queued on start,
// then popped and compared when done is seen.
module tb_minv_mdiv_seq;
  import minv_mdiv_seq_pkg::*;

  localparam int TB_TIMEOUT  = 16;
  localparam int MODEL_DELAY = 3;   // gives 4 WAIT cycles
  localparam logic [OP_W-1:0] PAT =
    256'h201F1E1D_1C1B1A19_18171615_14131211_100F0E0D_0C0B0A09_08070605_04030201;

  typedef struct {
    logic            mode;
    logic [OP_W-1:0] a, b, p;
    bit              echo, never;
    logic [OP_W-1:0] x1, x2;
    logic            flag, errv;
    int              lat;
  } vec_t;

  typedef struct {
    logic [OP_W-1:0] x1, x2;
    logic            flag, errv;
    int              lat;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [OP_W-1:0] op_a = '0, op_b = '0, op_p = '0;
  logic busy, done, err, res_flag;
  logic [OP_W-1:0] res_x1, res_x2;

  minv_mdiv_seq_if cif ();

  minv_mdiv_seq #(.RDY_GAP(2), .RD_LAT(1), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .op_a(op_a), .op_b(op_b), .op_p(op_p),
    .busy(busy), .done(done), .err(err),
    .res_x1(res_x1), .res_x2(res_x2), .res_flag(res_flag),
    .core(cif)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int cyc = 0;
  exp_t sb[$];
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural core model ----------------
  logic [OP_W-1:0] m_a, m_b, m_p, m_x1, m_x2, m_t1, m_t2;
  logic            m_tf;
  logic [3:0]      m_cnt;
  logic [2:0]      m_idx;
  bit              m_echo = 0, m_never = 0;

  function automatic void model_calc(input logic md, input logic [OP_W-1:0] a, b, p,
                                     input bit echo, output logic [OP_W-1:0] x1, x2,
                                     output logic fl);
    longint unsigned aa, bb, pp, inv;
    x1 = a; x2 = a; fl = 1'b1;
    if (!echo) begin
      aa = 64'(a[31:0]); bb = 64'(b[31:0]); pp = 64'(p[31:0]); inv = 0;
      for (longint unsigned i = 1; i < pp; i++) begin
        if ((aa * i) % pp == 1) begin inv = i; break; end
      end
      fl = (inv != 0);
      x2 = OP_W'(inv);
      x1 = (md == MODE_INV) ? OP_W'(inv) : OP_W'((bb * inv) % pp);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cif.core_rdy <= 1'b0; cif.core_flag <= 1'b0;
      cif.core_regx1out <= '0; cif.core_regx2out <= '0;
      m_a <= '0; m_b <= '0; m_p <= '0; m_x1 <= '0; m_x2 <= '0;
      m_cnt <= '0; m_idx <= '0;
    end else begin
      if (cif.core_loada) begin
        m_a <= {cif.core_datain, m_a[OP_W-1:WORD_W]};
        cif.core_rdy <= 1'b0;
      end
      if (cif.core_loadp) m_p <= {cif.core_datain, m_p[OP_W-1:WORD_W]};
      if (cif.core_loadb) m_b <= {cif.core_datain, m_b[OP_W-1:WORD_W]};
      if (cif.core_en) begin
        model_calc(cif.core_minv_mdiv, m_a, m_b, m_p, m_echo, m_t1, m_t2, m_tf);
        m_x1 <= m_t1; m_x2 <= m_t2; cif.core_flag <= m_tf;
        m_idx <= '0; cif.core_rdy <= 1'b0;
        m_cnt <= m_never ? 4'd0 : 4'(MODEL_DELAY);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 4'd1;
        if (m_cnt == 4'd1) cif.core_rdy <= 1'b1;
      end
      if (cif.core_outx1) begin
        cif.core_regx1out <= m_x1[m_idx*WORD_W +: WORD_W];
        cif.core_regx2out <= m_x2[m_idx*WORD_W +: WORD_W];
        m_idx <= m_idx + 3'd1;
      end
    end
  end

  // ---------------- bus monitors ----------------
  int n_loada = 0, n_loadp = 0, n_loadb = 0, n_en = 0, n_outx = 0, n_done = 0, n_viol = 0;
  int nstrb;
  logic [33:0] ld_log[$];

  always @(negedge clk) begin
    nstrb = int'(cif.core_loada) + int'(cif.core_loadp) + int'(cif.core_loadb);
    if (cif.core_loada) n_loada++;
    if (cif.core_loadp) n_loadp++;
    if (cif.core_loadb) n_loadb++;
    if (cif.core_en) n_en++;
    if (cif.core_outx1) n_outx++;
    if (done) n_done++;
    if (nstrb > 1) n_viol++;
    if (nstrb == 0 && cif.core_datain != '0) n_viol++;
    if (cif.core_outx1 != cif.core_outx2) n_viol++;
    if (nstrb == 1)
      ld_log.push_back({cif.core_loada ? 2'd1 : cif.core_loadp ? 2'd2 : 2'd3, cif.core_datain});
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int lat);
    exp_t e;
    chk_int("sb_nonempty", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_x1", res_x1, e.x1);
      chk("res_x2", res_x2, e.x2);
      chk_int("res_flag", int'(res_flag), int'(e.flag));
      chk_int("err", int'(err), int'(e.errv));
      chk_int("latency", lat, e.lat);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int restart_at);
    exp_t e;
    int t0, t1, s_la, s_lp, s_lb, s_en, s_ox, s_log, n_exp;
    bit seen, ok;
    logic [OP_W-1:0] src;
    logic [33:0] ex;
    m_echo = v.echo; m_never = v.never;
    @(negedge clk);
    s_la = n_loada; s_lp = n_loadp; s_lb = n_loadb; s_en = n_en; s_ox = n_outx;
    s_log = ld_log.size();
    op_a = v.a; op_b = v.b; op_p = v.p; mode = v.mode; start = 1'b1; t0 = cyc;
    e.x1 = v.x1; e.x2 = v.x2; e.flag = v.flag; e.errv = v.errv; e.lat = v.lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk_int("busy_after_start", int'(busy), 1);
    chk_int("err_cleared", int'(err), 0);
    chk_int("mode_pin", int'(cif.core_minv_mdiv), int'(v.mode));
    if (restart_at > 0) begin
      repeat (restart_at - 1) @(negedge clk);
      op_a = 7; op_b = 1; op_p = 13; mode = ~v.mode; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    t1 = cyc;
    chk_int("done_seen", int'(seen), 1);
    if (seen) checkOutput(t1 - t0 + 1);
    else if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    chk_int("done_pulse", int'(done), 0);
    chk_int("busy_idle", int'(busy), 0);
    chk_int("err_hold", int'(err), int'(v.errv));
    #1;
    chk_int("loada_cycles", n_loada - s_la, 8);
    chk_int("loadp_cycles", n_loadp - s_lp, 8);
    chk_int("loadb_cycles", n_loadb - s_lb, v.mode ? 0 : 8);
    chk_int("en_cycles", n_en - s_en, 1);
    chk_int("outx_cycles", n_outx - s_ox, v.never ? 0 : 8);
    n_exp = v.mode ? 16 : 24;
    ok = (ld_log.size() - s_log == n_exp);
    for (int k = 0; k < n_exp && ok; k++) begin
      src = (k < 8) ? v.a : (k < 16) ? v.p : v.b;
      ex = {2'(k / 8 + 1), src[(k % 8)*WORD_W +: WORD_W]};
      if (ld_log[s_log + k] !== ex) ok = 0;
    end
    chk_int("load_seq", int'(ok), 1);
  endtask

  task automatic resetDuringRead(input vec_t v);
    int s_done;
    bit hit;
    m_echo = 0; m_never = 0;
    @(negedge clk);
    op_a = v.a; op_b = v.b; op_p = v.p; mode = v.mode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (cif.core_outx1) hit = 1;
      else @(negedge clk);
    end
    chk_int("read_reached", int'(hit), 1);
    repeat (3) @(negedge clk);
    s_done = n_done;
    #2 rst = 1'b1;
    #1;
    chk("rst_res_x1", res_x1, '0);
    chk("rst_res_x2", res_x2, '0);
    chk_int("rst_ctrl", int'({busy, done, err, res_flag, cif.core_loada, cif.core_loadp,
                              cif.core_loadb, cif.core_en, cif.core_outx1, cif.core_outx2,
                              cif.core_minv_mdiv}), 0);
    chk_int("rst_datain", int'(cif.core_datain), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk_int("no_done_after_rst", n_done - s_done, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{mode:1'b1, a:5, b:0, p:11, echo:0, never:0, x1:9,   x2:9,   flag:1'b1, errv:1'b0, lat:34};
    vecs[1] = '{mode:1'b0, a:5, b:3, p:11, echo:0, never:0, x1:5,   x2:9,   flag:1'b1, errv:1'b0, lat:42};
    vecs[2] = '{mode:1'b1, a:PAT, b:0, p:11, echo:1, never:0, x1:PAT, x2:PAT, flag:1'b1, errv:1'b0, lat:34};
    vecs[3] = '{mode:1'b0, a:5, b:3, p:11, echo:0, never:1, x1:PAT, x2:PAT, flag:1'b1, errv:1'b1, lat:43};
    vecs[4] = '{mode:1'b0, a:7, b:2, p:13, echo:0, never:0, x1:4,   x2:2,   flag:1'b1, errv:1'b0, lat:42};
    vecs[5] = '{mode:1'b1, a:6, b:0, p:9,  echo:0, never:0, x1:0,   x2:0,   flag:1'b0, errv:1'b0, lat:34};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_int("reset_ctrl", int'({busy, done, err, res_flag, cif.core_loada, cif.core_loadp,
                                cif.core_loadb, cif.core_en, cif.core_outx1, cif.core_outx2,
                                cif.core_minv_mdiv}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_res_x1", res_x1, '0);
    chk("reset_res_x2", res_x2, '0);
    chk_int("reset_datain", int'(cif.core_datain), 0);
    chk_int("reset_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 0);

    $display("[TB] restart during LOAD_P");
    applyStimulus(vecs[0], 12);

    $display("[TB] reset during READ");
    resetDuringRead(vecs[1]);
    applyStimulus(vecs[1], 0);

    chk_int("bus_protocol_violations", n_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/minv_mdiv_seq.md
Name: minv_mdiv_seq

Overview:
- Word-serial sequencer that sits directly upstream of the MINV_MDIV modular inverse/division core.
- Host side:
  - accepts three 256-bit operands (a, b, p) and a mode bit in one start cycle;
  - gets back 256-bit x1/x2 results and the core flag through a busy/done handshake.
- Core side: drives the 32-bit load, start and read-out protocol (loada, loadp, loadb, minv_mdiv_en, outx1/outx2), so no host ever sequences the core by hand.

Parameters:
- RDY_GAP, 2, idle cycles between detecting core rdy and the first outx1/outx2 cycle.
- RD_LAT, 1, cycles from an outx assertion cycle to the matching valid word on regx1out/regx2out.
- TIMEOUT, 4096, maximum cycles spent waiting for core rdy before aborting with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  1 = modular inversion (a^-1 mod p); 0 = modular division (b/a mod p).
- op_a  in  256  operand a.
- op_b  in  256  operand b; ignored when mode=1.
- op_p  in  256  modulus p.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are valid.
- err  out  1  timeout indication, valid with done.
- res_x1  out  256  assembled regx1out words.
- res_x2  out  256  assembled regx2out words.
- res_flag  out  1  core flag captured when rdy is detected.
- core_datain  out  32  word bus to the core.
- core_loada, core_loadp, core_loadb  out  1  load strobes to the core.
- core_minv_mdiv  out  1  mode to the core.
- core_en  out  1  start pulse to the core.
- core_outx1, core_outx2  out  1  read-out strobes to the core.
- core_regx1out, core_regx2out  in  32  result words from the core.
- core_rdy  in  1  core ready.
- core_flag  in  1  core status flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, applied through clk and rst.
  - All outputs go to 0, including res_x1, res_x2, res_flag and err.
  - State goes to IDLE.
  - Reset asserted mid-operation aborts immediately; no done is produced.
- IDLE, start=1:
  - latch op_a, op_b, op_p and mode;
  - raise busy the next cycle;
  - go to LOAD_A.
- start while busy is ignored.
- States: IDLE -> LOAD_A -> LOAD_P -> LOAD_B -> GO -> WAIT -> GAP -> READ -> FIN -> IDLE.
  - mode=1 skips LOAD_B: LOAD_P goes straight to GO.
- LOAD_A, LOAD_P, LOAD_B each last exactly 8 cycles.
  - The matching strobe is high for all 8 cycles.
  - core_datain = word k (bits 32k+31:32k) on the k-th cycle, k=0..7, least-significant word first.
  - A 3-bit word counter wraps from 7 to 0 at each state change.
  - Only one load strobe is ever high at a time; core_datain is 0 outside load states.
- core_minv_mdiv is held at the latched mode from LOAD_A through FIN, and is 0 in IDLE.
- GO: core_en high for exactly 1 cycle; then enter WAIT.
- WAIT:
  - Leave on the first cycle core_rdy is sampled high; capture core_flag into res_flag; enter GAP.
  - A core_rdy already high in GO is ignored; only WAIT samples it.
  - A cycle counter runs during WAIT. If it reaches TIMEOUT: set err=1, skip read-out, go to FIN.
- GAP: RDY_GAP cycles with all strobes low.
- READ:
  - core_outx1 and core_outx2 are both high for 8 consecutive cycles.
  - The word presented RD_LAT cycles after the k-th strobe cycle is written to bits 32k+31:32k of res_x1/res_x2.
  - READ lasts 8+RD_LAT cycles; strobes are low in the trailing RD_LAT cycles.
- FIN: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
  - res_* and err hold until the next accepted start.
  - On start, err clears; res_* are overwritten during READ.
- Latency, start to done, division, no timeout:
  - 1 + 24 + 1 + W + RDY_GAP + 8 + RD_LAT + 1, where W = number of WAIT cycles.
  - Inversion is 8 cycles shorter.

Decomposition:
- Shared package:
  - state enum;
  - WORDS=8, WORD_W=32, OP_W=256;
  - mode encodings MODE_INV=1, MODE_DIV=0.
- One natural sub-module: minv_mdiv_word_ser. It is an 8x32 shift/mux serialiser plus a deserialiser with word counter, reused for the load and read-out paths.
- The FSM stays in the top level.

Test Plan:
- Inversion: mode=1, a=5, p=11, behavioural core model.
  - core_loadb never rises.
  - datain sequence is 5,0,...,0 then 11,0,...,0.
  - res_x1=9, res_flag from model, done exactly once, err=0.
- Division: mode=0, a=5, b=3, p=11.
  - Load order is a, p, b, 24 strobe cycles in total.
  - core_en is a single cycle.
  - res_x1=5.
  - Start-to-done equals the latency formula with the model's W.
- Word order: a=256'h0807060504030201 repeated per word, with a model that echoes the loaded a as x1 and x2.
  - res_x1 == res_x2 == a, proving LSW-first in both directions and the RD_LAT alignment.
- Timeout: TIMEOUT=16, model never raises rdy.
  - done after 16 WAIT cycles with err=1.
  - core_outx1/core_outx2 never asserted.
- Robustness:
  - start pulsed again during LOAD_P -> ignored, operands unchanged.
  - rst asserted during READ -> all outputs 0 asynchronously, no done.
  - Next start then completes normally.
